// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitData
  } arb_state_t;

  typedef logic port_idx_t;

  localparam int unsigned DefAddrWidth = 25;
  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefTimeout   = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on contention the port not granted last time wins.
module rr_arbiter2
  import sdram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_idx_t  i_last_grant,
  output port_idx_t  o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    if (&i_req) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_req[0] ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM controller front end with one outstanding transaction
// and a read-data timeout.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p0_din,
  input  logic [DATA_WIDTH-1:0] p1_din,
  output logic                  p0_ack,
  output logic                  p1_ack,
  output logic                  p0_valid,
  output logic                  p1_valid,
  output logic [DATA_WIDTH-1:0] p_dout,
  output logic                  err,
  output logic                  ctrl_req,
  output logic                  ctrl_we,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic [DATA_WIDTH-1:0] ctrl_din,
  input  logic                  ctrl_ack,
  input  logic                  ctrl_valid,
  input  logic [DATA_WIDTH-1:0] ctrl_dout
);

  localparam int unsigned TimerWidth = $clog2(TIMEOUT + 1);

  arb_state_t            r_state, w_state_d;
  port_idx_t             r_grant, r_last_grant, w_rr_grant;
  logic                  w_rr_valid;
  logic                  r_ctrl_req, r_ctrl_we;
  logic [ADDR_WIDTH-1:0] r_ctrl_addr;
  logic [DATA_WIDTH-1:0] r_ctrl_din, r_p_dout;
  logic                  r_p0_valid, r_p1_valid, r_err;
  logic [TimerWidth-1:0] r_timer;
  logic                  w_grant_fire, w_ack_fire, w_data_fire, w_timeout_fire;

  rr_arbiter2 u_rr (
    .i_req       ({p1_req, p0_req}),
    .i_last_grant(r_last_grant),
    .o_grant     (w_rr_grant),
    .o_valid     (w_rr_valid)
  );

  always_comb begin
    w_state_d      = r_state;
    w_grant_fire   = 1'b0;
    w_ack_fire     = 1'b0;
    w_data_fire    = 1'b0;
    w_timeout_fire = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_rr_valid) begin
          w_grant_fire = 1'b1;
          w_state_d    = StIssue;
        end
      end
      StIssue: begin
        if (ctrl_ack) begin
          w_ack_fire = 1'b1;
          w_state_d  = r_ctrl_we ? StIdle : StWaitData;
        end
      end
      StWaitData: begin
        // Data arriving in the timeout cycle takes priority over err.
        if (ctrl_valid) begin
          w_data_fire = 1'b1;
          w_state_d   = StIdle;
        end else if (r_timer == TimerWidth'(TIMEOUT - 1)) begin
          w_timeout_fire = 1'b1;
          w_state_d      = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ctrl_req   <= 1'b0;
      r_ctrl_we    <= 1'b0;
      r_ctrl_addr  <= '0;
      r_ctrl_din   <= '0;
      r_p_dout     <= '0;
      r_p0_valid   <= 1'b0;
      r_p1_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_p0_valid <= w_data_fire & ~r_grant;
      r_p1_valid <= w_data_fire & r_grant;
      r_err      <= w_timeout_fire;
      if (w_grant_fire) begin
        r_grant      <= w_rr_grant;
        r_last_grant <= w_rr_grant;
        r_ctrl_req   <= 1'b1;
        r_ctrl_we    <= w_rr_grant ? p1_we : p0_we;
        r_ctrl_addr  <= w_rr_grant ? p1_addr : p0_addr;
        r_ctrl_din   <= w_rr_grant ? p1_din : p0_din;
      end
      if (w_ack_fire) begin
        r_ctrl_req <= 1'b0;
      end
      // Counter holds 0 on the first WAIT_DATA cycle, k on the (k+1)-th.
      if (w_ack_fire) begin
        r_timer <= '0;
      end else if (r_state == StWaitData) begin
        r_timer <= r_timer + TimerWidth'(1);
      end
      if (w_data_fire) begin
        r_p_dout <= ctrl_dout;
      end
    end
  end

  assign p0_ack    = w_ack_fire & ~r_grant;
  assign p1_ack    = w_ack_fire & r_grant;
  assign p0_valid  = r_p0_valid;
  assign p1_valid  = r_p1_valid;
  assign err       = r_err;
  assign p_dout    = r_p_dout;
  assign ctrl_req  = r_ctrl_req;
  assign ctrl_we   = r_ctrl_we;
  assign ctrl_addr = r_ctrl_addr;
  assign ctrl_din  = r_ctrl_din;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised scoreboard bench for sdram_arbiter: the driver plays both requesters
// and the controller, pushes expected events, and a negedge monitor pops them.
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int TO = 255;
  localparam int KAck   = 0;
  localparam int KValid = 1;
  localparam int KErr   = 2;

  typedef struct {
    int          kind;
    int          port;
    int          cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          p0_req, p1_req, p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_din, p1_din;
  logic          p0_ack, p1_ack, p0_valid, p1_valid, err;
  logic [DW-1:0] p_dout;
  logic          ctrl_req, ctrl_we, ctrl_ack, ctrl_valid;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_din, ctrl_dout;

  sdram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .p0_we     (p0_we),
    .p1_we     (p1_we),
    .p0_addr   (p0_addr),
    .p1_addr   (p1_addr),
    .p0_din    (p0_din),
    .p1_din    (p1_din),
    .p0_ack    (p0_ack),
    .p1_ack    (p1_ack),
    .p0_valid  (p0_valid),
    .p1_valid  (p1_valid),
    .p_dout    (p_dout),
    .err       (err),
    .ctrl_req  (ctrl_req),
    .ctrl_we   (ctrl_we),
    .ctrl_addr (ctrl_addr),
    .ctrl_din  (ctrl_din),
    .ctrl_ack  (ctrl_ack),
    .ctrl_valid(ctrl_valid),
    .ctrl_dout (ctrl_dout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   mon_acks0 = 0;
  int   mon_acks1 = 0;

  // Requester-side model state: pending requests and round-robin history.
  logic          tb_req[2];
  logic          tb_we[2];
  logic [AW-1:0] tb_addr[2];
  logic [DW-1:0] tb_din[2];
  logic          m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int port, input int c, input logic [DW-1:0] d);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.cyc  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic mon_evt(input int kind, input int port);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d port=%0d cycle=%0d, expected no event",
               kind, port, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.port != port || e.cyc != cyc ||
          (kind == KValid && p_dout !== e.data)) begin
        failures++;
        $display("FAIL event: got kind=%0d port=%0d cycle=%0d dout=0x%0h, expected kind=%0d port=%0d cycle=%0d dout=0x%0h",
                 kind, port, cyc, p_dout, e.kind, e.port, e.cyc, e.data);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (p0_ack) begin mon_acks0++; mon_evt(KAck, 0); end
      if (p1_ack) begin mon_acks1++; mon_evt(KAck, 1); end
      if (p0_valid) mon_evt(KValid, 0);
      if (p1_valid) mon_evt(KValid, 1);
      if (err) mon_evt(KErr, -1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply();
    p0_req  = tb_req[0];  p1_req  = tb_req[1];
    p0_we   = tb_we[0];   p1_we   = tb_we[1];
    p0_addr = tb_addr[0]; p1_addr = tb_addr[1];
    p0_din  = tb_din[0];  p1_din  = tb_din[1];
  endtask

  task automatic new_req(input logic p, input logic we);
    tb_req[p]  = 1'b1;
    tb_we[p]   = we;
    tb_addr[p] = AW'($urandom);
    tb_din[p]  = DW'($urandom);
  endtask

  function automatic logic pick();
    if (tb_req[0] && tb_req[1]) return ~m_last;
    return tb_req[0] ? 1'b0 : 1'b1;
  endfunction

  // One transaction, starting in a cycle where the DUT is idle and a request is up.
  // data_dly: cycles from ack to ctrl_valid; above TO means the data never comes.
  task automatic round(input int ack_dly, input int data_dly, input logic [DW-1:0] rdata);
    logic          w;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    int            a;
    w      = pick();
    m_last = w;
    e_we   = tb_we[w];
    e_addr = tb_addr[w];
    e_din  = tb_din[w];
    step();
    chk("ctrl_req_rise", 64'(ctrl_req), 64'(1));
    chk("ctrl_we", 64'(ctrl_we), 64'(e_we));
    chk("ctrl_addr", 64'(ctrl_addr), 64'(e_addr));
    chk("ctrl_din", 64'(ctrl_din), 64'(e_din));
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk("ctrl_req_hold", 64'(ctrl_req), 64'(1));
      chk("ctrl_addr_hold", 64'(ctrl_addr), 64'(e_addr));
    end
    ctrl_ack = 1'b1;
    a = cyc;
    push(KAck, int'(w), a, '0);
    step();
    ctrl_ack = 1'b0;
    tb_req[w] = 1'b0;
    apply();
    chk("ctrl_req_drop", 64'(ctrl_req), 64'(0));
    if (!e_we) begin
      if (data_dly <= TO) begin
        repeat (data_dly - 1) step();
        ctrl_valid = 1'b1;
        ctrl_dout  = rdata;
        push(KValid, int'(w), cyc + 1, rdata);
        step();
        ctrl_valid = 1'b0;
      end else begin
        push(KErr, -1, a + 1 + TO, '0);
        repeat (TO) step();
      end
    end
  endtask

  initial begin
    logic pi;
    reset = 1'b1;
    ctrl_ack = 1'b1;
    ctrl_valid = 1'b1;
    ctrl_dout = 16'hFFFF;
    for (int p = 0; p < 2; p++) begin
      pi = p[0];
      tb_req[pi] = 1'b0; tb_we[pi] = 1'b0; tb_addr[pi] = '0; tb_din[pi] = '0;
    end
    m_last = 1'b1;
    apply();
    repeat (3) step();
    chk("rst_ctrl_req", 64'(ctrl_req), 64'(0));
    chk("rst_ctrl_we", 64'(ctrl_we), 64'(0));
    chk("rst_ctrl_addr", 64'(ctrl_addr), 64'(0));
    chk("rst_ctrl_din", 64'(ctrl_din), 64'(0));
    chk("rst_p_dout", 64'(p_dout), 64'(0));
    chk("rst_acks", 64'({p0_ack, p1_ack}), 64'(0));
    chk("rst_valids_err", 64'({p0_valid, p1_valid, err}), 64'(0));
    ctrl_ack = 1'b0;
    ctrl_valid = 1'b0;
    reset = 1'b0;
    step();

    // Contention right after reset: continuous writes, immediate ack.
    new_req(1'b0, 1'b1);
    new_req(1'b1, 1'b1);
    apply();
    for (int n = 0; n < 8; n++) begin
      round(0, 0, '0);
      if (n < 6) begin
        for (int p = 0; p < 2; p++) begin
          pi = p[0];
          if (!tb_req[pi]) new_req(pi, 1'b1);
        end
        apply();
      end
    end
    step();
    chk("contention_p0_acks", 64'(mon_acks0), 64'(4));
    chk("contention_p1_acks", 64'(mon_acks1), 64'(4));

    // Single p1 write, ack on the second ISSUE cycle.
    tb_req[1] = 1'b1; tb_we[1] = 1'b1; tb_addr[1] = 25'h000123; tb_din[1] = 16'hBEEF;
    apply();
    round(1, 0, '0);

    // p0 read at the top address, data 5 cycles after ack.
    tb_req[0] = 1'b1; tb_we[0] = 1'b0; tb_addr[0] = 25'h1FFFFFF; tb_din[0] = 16'h0000;
    apply();
    round(0, 5, 16'h5A5A);
    repeat (3) step();
    chk("p_dout_hold", 64'(p_dout), 64'(16'h5A5A));

    // Randomised mix of reads and writes from both ports.
    for (int n = 0; n < 20; n++) begin
      for (int p = 0; p < 2; p++) begin
        pi = p[0];
        if (!tb_req[pi] && $urandom_range(0, 1) == 1) new_req(pi, 1'($urandom_range(0, 1)));
      end
      if (!tb_req[0] && !tb_req[1]) new_req(1'b0, 1'($urandom_range(0, 1)));
      apply();
      round(int'($urandom_range(0, 3)), int'($urandom_range(1, 8)), DW'($urandom));
    end
    while (tb_req[0] || tb_req[1]) round(0, 2, 16'h0F0F);

    // Timeout on a p0 read, then a normal p1 write.
    new_req(1'b0, 1'b0);
    apply();
    round(2, TO + 100, '0);
    new_req(1'b1, 1'b1);
    apply();
    round(0, 0, '0);

    // Data arriving exactly in the timeout cycle wins.
    new_req(1'b1, 1'b0);
    apply();
    round(0, TO, 16'hC3C3);

    // Stray controller strobes while idle must produce nothing.
    ctrl_valid = 1'b1;
    ctrl_ack   = 1'b1;
    ctrl_dout  = 16'h1111;
    chk("stray_ack", 64'({p0_ack, p1_ack}), 64'(0));
    step();
    ctrl_valid = 1'b0;
    ctrl_ack   = 1'b0;
    chk("stray_valid_err", 64'({p0_valid, p1_valid, err}), 64'(0));
    chk("stray_p_dout", 64'(p_dout), 64'(16'hC3C3));
    chk("stray_ctrl_req", 64'(ctrl_req), 64'(0));

    // Reset in the middle of a p0 read while waiting for data.
    new_req(1'b0, 1'b0);
    apply();
    m_last = pick();
    step();
    ctrl_ack = 1'b1;
    push(KAck, 0, cyc, '0);
    step();
    ctrl_ack = 1'b0;
    tb_req[0] = 1'b0;
    apply();
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ctrl", 64'({ctrl_req, ctrl_we}), 64'(0));
    chk("midrst_ctrl_addr", 64'(ctrl_addr), 64'(0));
    chk("midrst_p_dout", 64'(p_dout), 64'(0));
    chk("midrst_pulses", 64'({p0_ack, p1_ack, p0_valid, p1_valid, err}), 64'(0));
    ctrl_valid = 1'b1;
    ctrl_dout = 16'h7777;
    step();
    step();
    reset = 1'b0;
    m_last = 1'b1;
    step();
    step();
    ctrl_valid = 1'b0;
    step();
    chk("postrst_p_dout", 64'(p_dout), 64'(0));
    new_req(1'b0, 1'b1);
    new_req(1'b1, 1'b1);
    apply();
    round(0, 0, '0);
    round(0, 0, '0);
    repeat (3) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
